spart_driver: RTL



---
 rtl/spart_driver.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spart_driver.sv
// spart_driver: bus-master sequencer for the mini-SPART bus interface.
// Programs the baud divisor, then polls status and echoes every received
// byte back to the transmitter through a small FIFO.
// All bus outputs are registered from the next-state decode, so no input
// reaches iocs/iorw/ioaddr/bus_wdata combinationally. The low divisor byte
// and br_cfg_q are both captured on the edge that enters CFG_LO, so both
// divisor bytes always come from the same br_cfg value.
module spart_driver #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_4800   = 16'h0515,
    parameter logic [15:0] DIV_9600   = 16'h028A,
    parameter logic [15:0] DIV_19200  = 16'h0145,
    parameter logic [15:0] DIV_38400  = 16'h00A2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    br_cfg,
    output logic                          iocs,
    output logic                          iorw,
    output logic [1:0]                    ioaddr,
    output logic [7:0]                    bus_wdata,
    input  logic [7:0]                    bus_rdata,
    input  logic                          rda,
    input  logic                          tbr,
    output logic [7:0]                    rx_data,
    output logic                          rx_strobe,
    output logic                          cfg_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        RST    = 3'd0,
        CFG_LO = 3'd1,
        CFG_HI = 3'd2,
        POLL   = 3'd3,
        RX_RD  = 3'd4,
        TX_WR  = 3'd5
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        br_cfg_q;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_head;
    logic [15:0]       div_live;
    logic [15:0]       div_cfg;
    logic              nxt_iocs;
    logic              nxt_iorw;
    logic [1:0]        nxt_addr;
    logic [7:0]        nxt_wdata;

    function automatic logic [15:0] div_for(input logic [1:0] sel);
        case (sel)
            2'b00:   div_for = DIV_4800;
            2'b01:   div_for = DIV_9600;
            2'b10:   div_for = DIV_19200;
            default: div_for = DIV_38400;
        endcase
    endfunction

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_head  = mem[rd_ptr[PTR_W-1:0]];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST;
        else        state <= next_state;
    end

    // Next-state selection and the bus outputs that belong to the next state
    always_comb begin
        next_state = state;
        div_live   = div_for(br_cfg);
        div_cfg    = div_for(br_cfg_q);
        nxt_iocs   = 1'b1;
        nxt_iorw   = 1'b1;
        nxt_addr   = 2'b01;
        nxt_wdata  = 8'h00;
        case (state)
            RST:    next_state = CFG_LO;
            CFG_LO: next_state = CFG_HI;
            CFG_HI: next_state = POLL;
            POLL: begin
                if (br_cfg != br_cfg_q)        next_state = CFG_LO;
                else if (rda && !fifo_full)    next_state = RX_RD;
                else if (tbr && !fifo_empty)   next_state = TX_WR;
                else                           next_state = POLL;
            end
            RX_RD:  next_state = POLL;
            TX_WR:  next_state = POLL;
            default: next_state = RST;
        endcase
        case (next_state)
            RST: begin
                nxt_iocs = 1'b0;
                nxt_addr = 2'b00;
            end
            CFG_LO: begin
                nxt_iorw  = 1'b0;
                nxt_addr  = 2'b10;
                nxt_wdata = div_live[7:0];
            end
            CFG_HI: begin
                nxt_iorw  = 1'b0;
                nxt_addr  = 2'b11;
                nxt_wdata = div_cfg[15:8];
            end
            RX_RD: nxt_addr = 2'b00;
            TX_WR: begin
                nxt_iorw  = 1'b0;
                nxt_addr  = 2'b00;
                nxt_wdata = fifo_head;
            end
            default: ;
        endcase
    end

    // Registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iocs      <= 1'b0;
            iorw      <= 1'b1;
            ioaddr    <= 2'b00;
            bus_wdata <= 8'h00;
        end else begin
            iocs      <= nxt_iocs;
            iorw      <= nxt_iorw;
            ioaddr    <= nxt_addr;
            bus_wdata <= nxt_wdata;
        end
    end

    // Configuration tracking, received byte capture and FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cfg_q  <= 2'b00;
            cfg_done  <= 1'b0;
            rx_data   <= 8'h00;
            rx_strobe <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            rx_strobe <= (state == RX_RD);
            if (next_state == CFG_LO)
                br_cfg_q <= br_cfg;
            if (state == CFG_HI)
                cfg_done <= 1'b1;
            else if (state == POLL && br_cfg != br_cfg_q)
                cfg_done <= 1'b0;
            if (state == RX_RD) begin
                rx_data <= bus_rdata;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (state == TX_WR)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Echo FIFO storage; contents are meaningless once the pointers are reset
    always_ff @(posedge clk) begin
        if (state == RX_RD)
            mem[wr_ptr[PTR_W-1:0]] <= bus_rdata;
    end

endmodule
